// File: rtl/interrupt_controller_if.sv
// Bus bundle between the interrupt controller, the MMU register bus and the CPU core.
// The master modport belongs to the CPU/MMU side. The slave modport belongs to the controller.
interface interrupt_controller_if #(
  parameter int NUM_IRQ = 5
);
  logic [15:0]        A_mmu;
  logic [7:0]         Di_mmu;
  logic [7:0]         Do_mmu;
  logic               wr_mmu;
  logic               rd_mmu;
  logic               cs_mmu;
  logic [NUM_IRQ-1:0] irq_in;
  logic               ime_set;
  logic               ime_clr;
  logic               int_req;
  logic [15:0]        int_vector;
  logic               int_ack;
  logic               wake;

  modport master (
    output A_mmu, Di_mmu, wr_mmu, rd_mmu, cs_mmu, irq_in, ime_set, ime_clr, int_ack,
    input  Do_mmu, int_req, int_vector, wake
  );

  modport slave (
    input  A_mmu, Di_mmu, wr_mmu, rd_mmu, cs_mmu, irq_in, ime_set, ime_clr, int_ack,
    output Do_mmu, int_req, int_vector, wake
  );
endinterface

// File: rtl/interrupt_controller.sv
// Holds IF/IE/IME and latches rising edges on the peripheral IRQ lines.
// Runs the dispatch handshake with the CPU, with source 0 highest priority, and drives the HALT wake line.
module interrupt_controller #(
  parameter int          NUM_IRQ       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter logic [15:0] VECTOR_STRIDE = 16'd8
) (
  input logic                   clock,
  input logic                   reset,
  interrupt_controller_if.slave bus
);

  localparam int          SEL_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_REQ  = 2'd1;
  localparam logic [1:0]  ST_ACKW = 2'd2;
  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  logic [NUM_IRQ-1:0] irq_q_r;
  logic [NUM_IRQ-1:0] if_r;
  logic [NUM_IRQ-1:0] ie_r;
  logic               ime_r;
  logic [1:0]         state_r;
  logic               int_req_r;
  logic [15:0]        int_vector_r;

  logic [NUM_IRQ-1:0] rise_s;
  logic [NUM_IRQ-1:0] pending_s;
  logic [NUM_IRQ-1:0] ack_clr_s;
  logic [NUM_IRQ-1:0] if_next_s;
  logic               ime_next_s;
  logic               if_wr_s;
  logic               ie_wr_s;
  logic               accept_s;
  logic [SEL_W-1:0]   sel_s;
  logic [15:0]        vec_s;
  logic [7:0]         rd_data_s;
  logic               unused_di_s;

  assign rise_s      = bus.irq_in & ~irq_q_r;
  assign pending_s   = if_r & ie_r;
  assign if_wr_s     = bus.cs_mmu & bus.wr_mmu & (bus.A_mmu == ADDR_IF);
  assign ie_wr_s     = bus.cs_mmu & bus.wr_mmu & (bus.A_mmu == ADDR_IE);
  assign accept_s    = (state_r == ST_REQ) & bus.int_ack;
  assign unused_di_s = ^bus.Di_mmu[7:NUM_IRQ];

  // Priority encoder: the lowest pending index wins.
  always_comb begin
    sel_s = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_s[i]) begin
        sel_s = SEL_W'(i);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Vector for the current winner. Zero when nothing is pending, which covers a cancelled dispatch.
  always_comb begin
    if (|pending_s) begin
      vec_s = VECTOR_BASE + (16'(sel_s) * VECTOR_STRIDE);
    end else begin
      vec_s = 16'h0000;
    end
  end

  // One-hot clear of the bit accepted by the CPU.
  always_comb begin
    ack_clr_s = '0;
    if (accept_s && (|pending_s)) begin
      ack_clr_s[sel_s] = 1'b1;
    end else begin
      ack_clr_s = '0;
    end
  end

  // IF next state: an MMU write loads first, then the ack clear applies. New edges OR in last so they are never lost.
  always_comb begin
    if (if_wr_s) begin
      if_next_s = (bus.Di_mmu[NUM_IRQ-1:0] & ~ack_clr_s) | rise_s;
    end else begin
      if_next_s = (if_r & ~ack_clr_s) | rise_s;
    end
  end

  // IME next state: accept and DI take precedence over EI/RETI.
  always_comb begin
    if (accept_s || bus.ime_clr) begin
      ime_next_s = 1'b0;
    end else if (bus.ime_set) begin
      ime_next_s = 1'b1;
    end else begin
      ime_next_s = ime_r;
    end
  end

  // Register read mux. Unused IF bits read as 1 and unused IE bits read as 0.
  always_comb begin
    rd_data_s = 8'h00;
    if (bus.cs_mmu && bus.rd_mmu) begin
      case (bus.A_mmu)
        ADDR_IF: begin
          rd_data_s                = 8'hFF;
          rd_data_s[NUM_IRQ-1:0]   = if_r;
        end
        ADDR_IE: begin
          rd_data_s                = 8'h00;
          rd_data_s[NUM_IRQ-1:0]   = ie_r;
        end
        default: rd_data_s = 8'h00;
      endcase
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // Interrupt registers and edge-detect history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_q_r <= '0;
      if_r    <= '0;
      ie_r    <= '0;
      ime_r   <= 1'b0;
    end else begin
      irq_q_r <= bus.irq_in;
      if_r    <= if_next_s;
      ime_r   <= ime_next_s;
      if (ie_wr_s) begin
        ie_r <= bus.Di_mmu[NUM_IRQ-1:0];
      end else begin
        ie_r <= ie_r;
      end
    end
  end

  // Dispatch FSM. Once raised, a request runs to the ack even if IME drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      int_req_r    <= 1'b0;
      int_vector_r <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ime_r && (|pending_s)) begin
            state_r      <= ST_REQ;
            int_req_r    <= 1'b1;
            int_vector_r <= vec_s;
          end else begin
            int_req_r    <= 1'b0;
          end
        end
        ST_REQ: begin
          int_vector_r <= vec_s;
          if (bus.int_ack) begin
            state_r   <= ST_ACKW;
            int_req_r <= 1'b0;
          end else begin
            int_req_r <= 1'b1;
          end
        end
        ST_ACKW: begin
          int_req_r <= 1'b0;
          if (!bus.int_ack) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_ACKW;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          int_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Do_mmu     = rd_data_s;
  assign bus.int_req    = int_req_r;
  assign bus.int_vector = int_vector_r;
  assign bus.wake       = |pending_s;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
// Inputs change 1 ns after each rising edge. Outputs are sampled at that same point.
module tb_interrupt_controller;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  logic [7:0] rd;

  interrupt_controller_if #(.NUM_IRQ(5)) bus ();

  interrupt_controller #(
    .NUM_IRQ(5),
    .VECTOR_BASE(16'h0040),
    .VECTOR_STRIDE(16'd8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mmu_write(input logic [15:0] addr, input logic [7:0] data);
    bus.A_mmu  = addr;
    bus.Di_mmu = data;
    bus.cs_mmu = 1'b1;
    bus.wr_mmu = 1'b1;
    tick();
    bus.cs_mmu = 1'b0;
    bus.wr_mmu = 1'b0;
  endtask

  task automatic mmu_read(input logic [15:0] addr, output logic [7:0] data);
    bus.A_mmu  = addr;
    bus.cs_mmu = 1'b1;
    bus.rd_mmu = 1'b1;
    #1;
    data = bus.Do_mmu;
    bus.cs_mmu = 1'b0;
    bus.rd_mmu = 1'b0;
  endtask

  task automatic pulse_ime_set();
    bus.ime_set = 1'b1;
    tick();
    bus.ime_set = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req: got %b expected 0", bus.int_req); end
    checks++; if (bus.int_vector !== 16'h0000) begin errors++; $display("FAIL reset_vector: got %h expected 0000", bus.int_vector); end
    checks++; if (bus.wake !== 1'b0) begin errors++; $display("FAIL reset_wake: got %b expected 0", bus.wake); end
    checks++; if (bus.Do_mmu !== 8'h00) begin errors++; $display("FAIL reset_do_idle: got %h expected 00", bus.Do_mmu); end
    reset = 1'b0;
    tick();
    mmu_read(16'hFF0F, rd);
    checks++; if (rd !== 8'hE0) begin errors++; $display("FAIL reset_if_read: got %h expected E0", rd); end
    mmu_read(16'hFFFF, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_ie_read: got %h expected 00", rd); end
  endtask

  task automatic test_timer_edge();
    logic extra_req;
    logic if_changed;
    mmu_write(16'hFFFF, 8'h04);
    pulse_ime_set();
    bus.irq_in[2] = 1'b1;
    tick();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL timer_req_n1: got %b expected 0", bus.int_req); end
    mmu_read(16'hFF0F, rd);
    checks++; if (rd !== 8'hE4) begin errors++; $display("FAIL timer_if_set: got %h expected E4", rd); end
    tick();
    checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL timer_req_n2: got %b expected 1", bus.int_req); end
    checks++; if (bus.int_vector !== 16'h0050) begin errors++; $display("FAIL timer_vector: got %h expected 0050", bus.int_vector); end
    bus.int_ack = 1'b1;
    tick();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL timer_req_drop: got %b expected 0", bus.int_req); end
    mmu_read(16'hFF0F, rd);
    checks++; if (rd !== 8'hE0) begin errors++; $display("FAIL timer_if_cleared: got %h expected E0", rd); end
    bus.int_ack = 1'b0;
    tick();
    extra_req  = 1'b0;
    if_changed = 1'b0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (bus.int_req !== 1'b0) extra_req = 1'b1;
      mmu_read(16'hFF0F, rd);
      if (rd !== 8'hE0) if_changed = 1'b1;
    end
    checks++; if (extra_req !== 1'b0) begin errors++; $display("FAIL timer_no_rerequest: got %b expected 0", extra_req); end
    checks++; if (if_changed !== 1'b0) begin errors++; $display("FAIL timer_if_once: got %b expected 0", if_changed); end
    // IME must have been cleared by the accept: pending again but no request
    mmu_write(16'hFF0F, 8'h04);
    tick();
    tick();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL timer_ime_cleared: got %b expected 0", bus.int_req); end
    mmu_write(16'hFF0F, 8'h00);
    bus.irq_in[2] = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    mmu_write(16'hFFFF, 8'h1F);
    mmu_write(16'hFF0F, 8'h1C);
    pulse_ime_set();
    tick();
    checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL prio_req: got %b expected 1", bus.int_req); end
    checks++; if (bus.int_vector !== 16'h0050) begin errors++; $display("FAIL prio_vec_before: got %h expected 0050", bus.int_vector); end
    bus.irq_in[0] = 1'b1;
    tick();
    tick();
    checks++; if (bus.int_vector !== 16'h0040) begin errors++; $display("FAIL prio_vec_preempt: got %h expected 0040", bus.int_vector); end
    bus.int_ack = 1'b1;
    tick();
    checks++; if (bus.int_vector !== 16'h0040) begin errors++; $display("FAIL prio_vec_latched: got %h expected 0040", bus.int_vector); end
    mmu_read(16'hFF0F, rd);
    checks++; if (rd !== 8'hFC) begin errors++; $display("FAIL prio_if_after_ack: got %h expected FC", rd); end
    bus.int_ack = 1'b0;
    bus.irq_in[0] = 1'b0;
    tick();
    mmu_write(16'hFF0F, 8'h00);
  endtask

  task automatic test_collision();
    bus.irq_in[3] = 1'b1;
    mmu_write(16'hFF0F, 8'h00);
    mmu_read(16'hFF0F, rd);
    checks++; if (rd !== 8'hE8) begin errors++; $display("FAIL collision_if: got %h expected E8", rd); end
    mmu_read(16'hFF10, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL other_addr_read: got %h expected 00", rd); end
    bus.irq_in[3] = 1'b0;
    mmu_write(16'hFF0F, 8'h00);
  endtask

  task automatic test_cancel();
    mmu_write(16'hFFFF, 8'h02);
    mmu_write(16'hFF0F, 8'h02);
    pulse_ime_set();
    tick();
    checks++; if (bus.int_vector !== 16'h0048) begin errors++; $display("FAIL cancel_vec: got %h expected 0048", bus.int_vector); end
    mmu_write(16'hFFFF, 8'h00);
    checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL cancel_req_held: got %b expected 1", bus.int_req); end
    bus.int_ack = 1'b1;
    tick();
    checks++; if (bus.int_vector !== 16'h0000) begin errors++; $display("FAIL cancel_vec_zero: got %h expected 0000", bus.int_vector); end
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL cancel_req_drop: got %b expected 0", bus.int_req); end
    mmu_read(16'hFF0F, rd);
    checks++; if (rd !== 8'hE2) begin errors++; $display("FAIL cancel_if_kept: got %h expected E2", rd); end
    bus.int_ack = 1'b0;
    tick();
    mmu_write(16'hFFFF, 8'h02);
    tick();
    tick();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL cancel_ime_cleared: got %b expected 0", bus.int_req); end
    mmu_write(16'hFF0F, 8'h00);
  endtask

  task automatic test_halt_wake();
    mmu_write(16'hFFFF, 8'h10);
    bus.irq_in[4] = 1'b1;
    tick();
    checks++; if (bus.wake !== 1'b1) begin errors++; $display("FAIL wake_set: got %b expected 1", bus.wake); end
    bus.A_mmu  = 16'hFF0F;
    bus.rd_mmu = 1'b1;
    #1;
    checks++; if (bus.Do_mmu !== 8'h00) begin errors++; $display("FAIL read_no_cs: got %h expected 00", bus.Do_mmu); end
    bus.rd_mmu = 1'b0;
    tick();
    tick();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL wake_no_req: got %b expected 0", bus.int_req); end
    mmu_write(16'hFF0F, 8'h00);
    checks++; if (bus.wake !== 1'b0) begin errors++; $display("FAIL wake_clear: got %b expected 0", bus.wake); end
    bus.irq_in[4] = 1'b0;
    tick();
  endtask

  task automatic test_ime_collision();
    mmu_write(16'hFFFF, 8'h01);
    bus.ime_set = 1'b1;
    bus.ime_clr = 1'b1;
    tick();
    bus.ime_set = 1'b0;
    bus.ime_clr = 1'b0;
    mmu_write(16'hFF0F, 8'h01);
    tick();
    tick();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL ime_clr_wins: got %b expected 0", bus.int_req); end
    pulse_ime_set();
    tick();
    checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL ime_set_req: got %b expected 1", bus.int_req); end
    checks++; if (bus.int_vector !== 16'h0040) begin errors++; $display("FAIL ime_set_vec: got %h expected 0040", bus.int_vector); end
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_dispatch();
    mmu_write(16'hFFFF, 8'h1F);
    mmu_write(16'hFF0F, 8'h1F);
    pulse_ime_set();
    tick();
    bus.int_ack = 1'b1;
    tick();
    mmu_write(16'hFF0F, 8'h1F);
    checks++; if (bus.int_vector !== 16'h0040) begin errors++; $display("FAIL ackw_vec_hold: got %h expected 0040", bus.int_vector); end
    checks++; if (bus.wake !== 1'b1) begin errors++; $display("FAIL ackw_wake: got %b expected 1", bus.wake); end
    reset = 1'b1;
    #1;
    checks++; if (bus.int_vector !== 16'h0000) begin errors++; $display("FAIL rst_mid_vec: got %h expected 0000", bus.int_vector); end
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b expected 0", bus.int_req); end
    checks++; if (bus.wake !== 1'b0) begin errors++; $display("FAIL rst_mid_wake: got %b expected 0", bus.wake); end
    tick();
    reset = 1'b0;
    bus.int_ack = 1'b0;
    mmu_read(16'hFF0F, rd);
    checks++; if (rd !== 8'hE0) begin errors++; $display("FAIL rst_mid_if: got %h expected E0", rd); end
    mmu_read(16'hFFFF, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_mid_ie: got %h expected 00", rd); end
    tick();
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    bus.A_mmu   = 16'h0000;
    bus.Di_mmu  = 8'h00;
    bus.wr_mmu  = 1'b0;
    bus.rd_mmu  = 1'b0;
    bus.cs_mmu  = 1'b0;
    bus.irq_in  = 5'b00000;
    bus.ime_set = 1'b0;
    bus.ime_clr = 1'b0;
    bus.int_ack = 1'b0;
    test_reset();
    test_timer_edge();
    test_priority();
    test_collision();
    test_cancel();
    test_halt_wake();
    test_ime_collision();
    test_reset_mid_dispatch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Owns the IF (FF0F) and IE (FFFF) registers and the master enable IME.
- Captures rising edges on the peripheral IRQ lines (VBlank, STAT, timer, serial, joypad) and picks the highest-priority pending-and-enabled source.
- Runs the dispatch handshake with the CPU and provides the halt-wake signal.
- Sits between the peripherals (including the timer's level timerIRQ) and the CPU core, on the same MMU register bus as the other I/O blocks.

Parameters:
NUM_IRQ, 5, number of interrupt sources; bit 0 has the highest priority.
VECTOR_BASE, 16'h0040, vector for source 0.
VECTOR_STRIDE, 8, byte spacing between consecutive vectors.

Ports:
clock  input  1  system clock; all state on its rising edge.
reset  input  1  asynchronous, active-high reset.
A_mmu  input  16  register address.
Di_mmu  input  8  write data.
Do_mmu  output  8  read data.
wr_mmu  input  1  write strobe.
rd_mmu  input  1  read strobe.
cs_mmu  input  1  chip select.
irq_in  input  NUM_IRQ  peripheral request levels; bit0 vblank, bit1 stat, bit2 timer, bit3 serial, bit4 joypad.
ime_set  input  1  one-cycle pulse from the CPU for EI/RETI; sets IME.
ime_clr  input  1  one-cycle pulse from the CPU for DI; clears IME.
int_req  output  1  dispatch request to the CPU.
int_vector  output  16  dispatch address.
int_ack  input  1  CPU accepts the dispatch; level, held until int_req drops.
wake  output  1  high while (IF & IE) is non-zero, independent of IME; used for HALT exit.

Behaviour:
- Reset (async): IF=0, IE=0, IME=0, edge-detect history=0, FSM=IDLE, int_req=0, int_vector=0, Do_mmu=0.
- Edge detect: rise[i] = irq_in[i] & ~irq_q[i]. irq_q is registered every cycle. A held level, such as the timer's, sets IF only once per rising edge.
- IF update priority, per bit, applied in this order within a cycle:
  1. MMU write to FF0F loads Di_mmu[NUM_IRQ-1:0].
  2. The dispatch clear on ack removes the dispatched bit.
  3. rise[i] ORs in last, so a new edge always survives a same-cycle write or clear.
- IE: MMU write to FFFF loads Di_mmu[NUM_IRQ-1:0].
- Read mux (combinational, valid when cs_mmu & rd_mmu, else 8'h00):
  - FF0F returns {3'b111, IF}.
  - FFFF returns {3'b000, IE}.
  - Any other address returns 8'h00.
- IME: ime_set sets it, ime_clr clears it. If both pulse in the same cycle, ime_clr wins. Dispatch acceptance clears IME.
- pending = IF & IE. sel = index of the lowest set bit of pending.
- FSM:
  - IDLE: if IME & |pending, go to REQ on the next edge with int_req=1.
  - REQ: int_req=1. int_vector = VECTOR_BASE + sel*VECTOR_STRIDE, updated every cycle so a higher-priority arrival preempts. If pending is empty, int_vector=16'h0000.
  - REQ, on int_ack=1: latch int_vector, clear IF[sel] (none if pending is empty), clear IME, drop int_req, go to ACKW.
  - ACKW: int_req=0, int_vector holds. When int_ack=0, go to IDLE.
  - IME dropping during REQ (via ime_clr) does not withdraw int_req. Once raised, the request completes.
- Latency: edge on irq_in at cycle n sets IF at n+1; int_req is high at n+2 when IME=1 and IE is set.
- wake is combinational from the registered IF/IE.
- Reset asserted mid-dispatch: immediate return to IDLE with all registers cleared. The CPU must tolerate int_req dropping without an ack.
- Widths: vector arithmetic is 16-bit unsigned. Unused IF/IE bits read as 1 (IF) and 0 (IE) respectively.

Test Plan:
- Timer edge: IE=04, IME set, irq_in[2] rises and is held high 50 cycles -> IF=04 once; int_req high 2 cycles after the edge, int_vector=0050; after ack, IF=00, IME=0, no second request while the level stays high.
- Priority: IE=1F, IF written 1C, then vblank edge during REQ before ack -> int_vector switches 0050 to 0040; ack clears only IF[0]; IF reads E0|1C=FC.
- Collision: MMU write FF0F=00 in the same cycle as a serial edge -> IF=08 and reads E8.
- Cancel: in REQ with vector 0048, write IE=00, then ack -> int_vector=0000, IF unchanged, IME=0.
- Halt wake: IME=0, IE=10, joypad edge -> wake=1, int_req stays 0; write FF0F=00 -> wake=0.
- Reset: assert reset during ACKW with IF=1F -> all outputs 0, IF reads E0, IE reads 00 immediately after the reset edge.
